lcr580_uart_port: RTL
=====================

// Module: lcr580_uart_port
// PURPOSE
//   Serial I/O peripheral on the LCR580 port bus, directly downstream of the CPU's IN/OUT path.
//   Decodes port_rd/port_we + address[7:0], buffers bytes in TX/RX FIFOs, runs an 8N1 UART.
//   Drives port_in back to the CPU.
// PARAMETERS
//   BASE        8'h10   data port = BASE, status port = BASE+1 (8-bit compare on address[7:0])
//   DIVISOR     217     clocks per serial bit (25 MHz / 115200); legal range 4..65535
//   DEPTH_LOG2  3       FIFO depth = 2**DEPTH_LOG2 entries, same for TX and RX
// PORTS
//   clock     in   1   system clock, all state on posedge
//   reset     in   1   asynchronous, active-high
//   ce        in   1   CPU clock enable; qualifies port_rd/port_we only
//   address   in   16  CPU address; port number = address[7:0]
//   out       in   8   CPU write data
//   port_we   in   1   CPU port write strobe
//   port_rd   in   1   CPU port read strobe
//   port_in   out  8   read data to CPU (combinational)
//   rxd       in   1   serial input, asynchronous
//   txd       out  1   serial output, idle high
//   irq       out  1   interrupt request (only with LCR_UART_IRQ_EN, else tied 0)
// BEHAVIOUR
//   Reset values: txd=1, irq=0, FIFOs empty, sticky flags 0, both FSMs IDLE, baud counters 0.
//   Reset mid-frame aborts the frame; txd returns high asynchronously.
//   Bus cycle: a strobe is accepted on a posedge where strobe && ce && address[7:0] matches.
//     Address and out are stable in the same cycle as the strobe.
//   port_in is combinational and valid in the strobe cycle; the CPU samples it on that edge.
//     address==BASE   -> RX FIFO head, or 8'h00 if RX empty.
//     address==BASE+1 -> status. Non-matching address -> 8'hFF.
//   Status byte: [0] RX not empty, [1] TX not full, [2] RX overrun (sticky),
//     [3] TX idle (FIFO empty and shifter IDLE), [4] framing error (sticky), [7:5] 0.
//   Read of BASE pops RX when not empty; read when empty returns 00 and pops nothing.
//   Read of BASE+1 clears [2] and [4] after the returned value (old value is read).
//   A flag set in the same cycle as a status read stays set.
//   Write to BASE pushes out into TX FIFO; write when full is dropped silently.
//   Write to BASE+1 is ignored.
//   FIFOs: pointers DEPTH_LOG2+1 bits wide, wrap mod 2**(DEPTH_LOG2+1).
//     full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
//     A push and a pop in the same cycle both take effect (count unchanged).
//     A push to a full RX FIFO is allowed when a pop happens in the same cycle.
//   TX FSM, IDLE->START->DATA->STOP->IDLE; counter counts DIVISOR-1..0 per bit; runs every clock.
//     IDLE: if TX FIFO not empty, pop it into the shifter and go to START.
//     START: txd=0 for one bit.
//     DATA: 8 bits, LSB first.
//     STOP: txd=1 for one bit. A queued byte starts next cycle (no extra idle bit).
//   RX FSM, IDLE->START->DATA->STOP->IDLE.
//     Synchroniser: rxd through 2 flops first; its output is rxs.
//     IDLE: falling rxs -> START, counter = DIVISOR/2.
//     START: at mid-bit rxs=1 -> IDLE (glitch), else DATA.
//     DATA: sample every DIVISOR clocks, 8 bits LSB first.
//     STOP: sample at mid-bit. If rxs=1, push the byte (full FIFO: byte dropped, overrun set).
//       If rxs=0, byte discarded, framing error set, and the FSM waits for rxs=1 before IDLE.
//   Latency: a write to an empty TX with IDLE shifter puts the start bit on txd 1 clock later.
//     A received byte is readable 1 clock after the mid-stop sample.
// CONFIGURATION
//   LCR_UART_IRQ_EN defined:
//     adds interrupt-enable register at BASE+2: [0] RX not empty, [1] TX idle; reset 0.
//     BASE+2 reads back as {6'b0, ier}.
//     irq is a registered output: (ier[0] & rx_not_empty) | (ier[1] & tx_idle).
//   Not defined: BASE+2 not decoded (reads FF, writes ignored); irq constant 0.
// TESTING
//   Reset, then read BASE+1 -> 8'h0A (TX not full, TX idle); txd=1.
//   OUT 8'h55 to BASE, DIVISOR=4 -> txd 0,1,0,1,0,1,0,1,0,1, each 4 clocks; status[3]=1 after stop bit.
//   Write 9 bytes 01..09 back-to-back (depth 8, shifter busy).
//     First byte shifts immediately, so all 9 accepted; 10th write while full dropped.
//     Exactly 9 frames on txd.
//   Loop txd->rxd, send A5. Read BASE+1 -> bit0=1; read BASE -> A5; next read BASE -> 00.
//   Drive 9 RX frames with no reads -> 8 stored, status[2]=1.
//     A second status read shows [2]=0. A frame with stop bit 0 -> status[4]=1, no push.
//   LCR_UART_IRQ_EN: write 01 to BASE+2, receive 3C -> irq=1. Read BASE -> irq=0 next clock.
//     Assert reset mid-frame -> txd=1 and irq=0 immediately.

Source files
------------

// File: rtl/lcr580_uart_port_if.sv
// LCR580 CPU port-bus bundle: strobes, address and write data from the CPU,
// and combinational read data back to it.
interface lcr580_uart_port_if;
    logic        ce;
    logic [15:0] address;
    logic [7:0]  out;
    logic        port_we;
    logic        port_rd;
    logic [7:0]  port_in;

    modport master (output ce, address, out, port_we, port_rd, input port_in);
    modport slave  (input ce, address, out, port_we, port_rd, output port_in);
endinterface

// File: rtl/lcr580_uart_port.sv
// 8N1 UART on the LCR580 port bus: data port at BASE, status at BASE+1, TX/RX FIFOs.
// Optional interrupt-enable register and irq output at BASE+2 under LCR_UART_IRQ_EN.
module lcr580_uart_port #(
    parameter logic [7:0]  BASE       = 8'h10,
    parameter int unsigned DIVISOR    = 217,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic              clock,
    input  logic              reset,
    lcr580_uart_port_if.slave bus,
    input  logic              rxd,
    output logic              txd,
    output logic              irq
);
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
    localparam logic [15:0] BIT_HALF  = 16'(DIVISOR / 2);
    localparam logic [7:0]  STAT_ADDR = BASE + 8'd1;

    typedef logic [DEPTH_LOG2:0] ptr_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic hit_data_s, hit_stat_s, rd_data_s, wr_data_s, rd_stat_s;
    logic unused_addr_s;
    assign hit_data_s    = (bus.address[7:0] == BASE);
    assign hit_stat_s    = (bus.address[7:0] == STAT_ADDR);
    assign rd_data_s     = bus.ce & bus.port_rd & hit_data_s;
    assign wr_data_s     = bus.ce & bus.port_we & hit_data_s;
    assign rd_stat_s     = bus.ce & bus.port_rd & hit_stat_s;
    assign unused_addr_s = ^bus.address[15:8];

    logic [7:0] tx_mem_q [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];
    ptr_t       tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic       tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic       tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic [7:0] tx_head_s, rx_head_s;

    assign tx_empty_s = (tx_wp_q == tx_rp_q);
    assign rx_empty_s = (rx_wp_q == rx_rp_q);
    assign tx_full_s  = (tx_wp_q[DEPTH_LOG2] != tx_rp_q[DEPTH_LOG2]) &&
                        (tx_wp_q[DEPTH_LOG2-1:0] == tx_rp_q[DEPTH_LOG2-1:0]);
    assign rx_full_s  = (rx_wp_q[DEPTH_LOG2] != rx_rp_q[DEPTH_LOG2]) &&
                        (rx_wp_q[DEPTH_LOG2-1:0] == rx_rp_q[DEPTH_LOG2-1:0]);
    assign tx_head_s  = tx_mem_q[tx_rp_q[DEPTH_LOG2-1:0]];
    assign rx_head_s  = rx_mem_q[rx_rp_q[DEPTH_LOG2-1:0]];
    assign tx_push_s  = wr_data_s & ~tx_full_s;
    assign rx_pop_s   = rd_data_s & ~rx_empty_s;

    tx_state_t   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        txd_q, tx_bit_end_s, tx_idle_s;

    assign tx_bit_end_s = (tx_cnt_q == 16'd0);
    // The shifter reloads straight from the end of a stop bit, so queued bytes go out without an idle gap.
    assign tx_pop_s     = ~tx_empty_s & ((tx_state_q == TX_IDLE) |
                                         ((tx_state_q == TX_STOP) & tx_bit_end_s));
    assign tx_idle_s    = tx_empty_s & (tx_state_q == TX_IDLE);

    rx_state_t   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [7:0]  rx_shift_q;
    logic [2:0]  rx_bit_q;
    logic        rx_meta_q, rxs_q, rx_bit_end_s, rx_stop_ok_s, rx_frame_err_s, overrun_set_s;
    logic        overrun_q, framing_q;

    assign rx_bit_end_s   = (rx_cnt_q == 16'd0);
    assign rx_stop_ok_s   = (rx_state_q == RX_STOP) & rx_bit_end_s & rxs_q;
    assign rx_frame_err_s = (rx_state_q == RX_STOP) & rx_bit_end_s & ~rxs_q;
    // A full RX FIFO still accepts the byte when the CPU pops in the same cycle.
    assign rx_push_s      = rx_stop_ok_s & (~rx_full_s | rx_pop_s);
    assign overrun_set_s  = rx_stop_ok_s & rx_full_s & ~rx_pop_s;

    // FIFO storage writes
    always_ff @(posedge clock) begin
        if (tx_push_s) tx_mem_q[tx_wp_q[DEPTH_LOG2-1:0]] <= bus.out;
        if (rx_push_s) rx_mem_q[rx_wp_q[DEPTH_LOG2-1:0]] <= rx_shift_q;
    end

    // FIFO pointers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            if (tx_push_s) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop_s)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push_s) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop_s)  rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

    // TX frame sequencer; txd is registered and forced high by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_shift_q <= 8'h00;
            tx_bit_q   <= 3'd0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop_s) begin
                        tx_shift_q <= tx_head_s;
                        tx_cnt_q   <= BIT_LAST;
                        txd_q      <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end_s) begin
                        tx_cnt_q   <= BIT_LAST;
                        tx_bit_q   <= 3'd0;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end_s) begin
                        tx_cnt_q <= BIT_LAST;
                        if (tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end_s) begin
                        if (tx_pop_s) begin
                            tx_shift_q <= tx_head_s;
                            tx_cnt_q   <= BIT_LAST;
                            txd_q      <= 1'b0;
                            tx_state_q <= TX_START;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: begin
                    txd_q      <= 1'b1;
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    // rxd synchroniser; resets to the idle level so no false start is seen
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // RX frame sequencer; IDLE is only entered with rxs high, so a low level there is a falling edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_shift_q <= 8'h00;
            rx_bit_q   <= 3'd0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rxs_q) begin
                        rx_cnt_q   <= BIT_HALF;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_bit_end_s) begin
                        if (rxs_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_cnt_q   <= BIT_LAST;
                            rx_bit_q   <= 3'd0;
                            rx_state_q <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end_s) begin
                        rx_shift_q <= {rxs_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= BIT_LAST;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end_s) rx_state_q <= rxs_q ? RX_IDLE : RX_WAIT;
                    else              rx_cnt_q   <= rx_cnt_q - 16'd1;
                end
                RX_WAIT: begin
                    if (rxs_q) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Sticky error flags: a set in the same cycle as a status read wins over the clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            overrun_q <= overrun_set_s  | (overrun_q & ~rd_stat_s);
            framing_q <= rx_frame_err_s | (framing_q & ~rd_stat_s);
        end
    end

    logic [7:0] status_s, port_in_s;
    assign status_s = {3'b000, framing_q, tx_idle_s, overrun_q, ~tx_full_s, ~rx_empty_s};

`ifdef LCR_UART_IRQ_EN
    logic [1:0] ier_q;
    logic       irq_q, hit_ier_s;
    assign hit_ier_s = (bus.address[7:0] == (BASE + 8'd2));

    // Interrupt enable register and registered interrupt request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ier_q <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            if (bus.ce & bus.port_we & hit_ier_s) ier_q <= bus.out[1:0];
            irq_q <= (ier_q[0] & ~rx_empty_s) | (ier_q[1] & tx_idle_s);
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read mux back to the CPU, valid in the strobe cycle
    always_comb begin
        port_in_s = 8'hFF;
        if (hit_data_s) begin
            if (rx_empty_s) port_in_s = 8'h00;
            else            port_in_s = rx_head_s;
        end else if (hit_stat_s) begin
            port_in_s = status_s;
`ifdef LCR_UART_IRQ_EN
        end else if (hit_ier_s) begin
            port_in_s = {6'b000000, ier_q};
`endif
        end else begin
            port_in_s = 8'hFF;
        end
    end

    assign bus.port_in = port_in_s;
    assign txd         = txd_q;
endmodule
